// File: rtl/lc3_decode_pkg.sv
// Shared opcodes, control-field encodings and the decoded-instruction bundle
// used by the buffered LC-3 decode stage.
package lc3_decode_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned E_W     = 6;
  localparam int unsigned W_W     = 2;

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  localparam logic [1:0] ALU_ADD = 2'd0;
  localparam logic [1:0] ALU_AND = 2'd1;
  localparam logic [1:0] ALU_NOT = 2'd2;

  localparam logic [1:0] PC1_NONE = 2'd0;
  localparam logic [1:0] PC1_OFF9 = 2'd1;
  localparam logic [1:0] PC1_OFF6 = 2'd2;
  localparam logic [1:0] PC1_BASE = 2'd3;

  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_ADDR = 2'd2;

  // Everything about one instruction except its next PC, whose width is a
  // parameter of the top and is therefore stored alongside.
  typedef struct packed {
    logic [INSTR_W-1:0] ir;
    logic [E_W-1:0]     e_ctrl;
    logic [W_W-1:0]     w_ctrl;
    logic               m_ctrl;
    logic               illegal;
  } dec_bundle_t;

  function automatic logic [E_W-1:0] pack_e(input logic [1:0] alu,
                                            input logic [1:0] pc1,
                                            input logic       pc2,
                                            input logic       op2);
    return {alu, pc1, pc2, op2};
  endfunction

endpackage

// File: rtl/lc3_decode_logic.sv
// Combinational LC-3 instruction decoder. Optional feature macro:
// LC3_DECODE_ILLEGAL_EN flags the unsupported opcodes through illegal.
module lc3_decode_logic
  import lc3_decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output dec_bundle_t        dec
);

  logic [3:0] opcode;
  logic       reg_op2;

  assign opcode  = instr[15:12];
  // Immediate-mode bit clear means the second operand comes from a register.
  assign reg_op2 = ~instr[5];

  always_comb begin
    dec         = '0;
    dec.ir      = instr;
    case (opcode)
      OP_ADD: dec.e_ctrl = pack_e(ALU_ADD, PC1_NONE, 1'b0, reg_op2);
      OP_AND: dec.e_ctrl = pack_e(ALU_AND, PC1_NONE, 1'b0, reg_op2);
      OP_NOT: dec.e_ctrl = pack_e(ALU_NOT, PC1_NONE, 1'b0, reg_op2);
      OP_BR:  dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
      OP_JMP: dec.e_ctrl = pack_e(ALU_ADD, PC1_BASE, 1'b0, 1'b0);
      OP_LD: begin
        dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        dec.w_ctrl = WB_MEM;
      end
      OP_LDR: begin
        dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
        dec.w_ctrl = WB_MEM;
      end
      OP_LDI: begin
        dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        dec.w_ctrl = WB_MEM;
        dec.m_ctrl = 1'b1;
      end
      OP_LEA: begin
        dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        dec.w_ctrl = WB_ADDR;
      end
      OP_ST:  dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
      OP_STR: dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF6, 1'b0, 1'b0);
      OP_STI: begin
        dec.e_ctrl = pack_e(ALU_ADD, PC1_OFF9, 1'b1, 1'b0);
        dec.m_ctrl = 1'b1;
      end
      default: begin
`ifdef LC3_DECODE_ILLEGAL_EN
        dec.illegal = 1'b1;
`else
        dec.illegal = 1'b0;
`endif
      end
    endcase
  end

endmodule

// File: rtl/lc3_decode_buffered.sv
// LC-3 decode stage with a BUF_DEPTH-entry decoded-instruction FIFO and
// valid/ready handshakes. Optional feature macro: LC3_DECODE_ILLEGAL_EN.
module lc3_decode_buffered
  import lc3_decode_pkg::*;
#(
  parameter int unsigned NPC_W     = 16,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [INSTR_W-1:0]             in_instr,
  input  logic [NPC_W-1:0]               in_npc,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [INSTR_W-1:0]             IR,
  output logic [NPC_W-1:0]               npc_out,
  output logic [E_W-1:0]                 E_Control,
  output logic [W_W-1:0]                 W_Control,
  output logic                           Mem_Control,
  output logic                           illegal_op,
  output logic [$clog2(BUF_DEPTH+1)-1:0] occupancy
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  dec_bundle_t in_dec;

  dec_bundle_t      buf_q     [BUF_DEPTH];
  dec_bundle_t      buf_d     [BUF_DEPTH];
  logic [NPC_W-1:0] npc_buf_q [BUF_DEPTH];
  logic [NPC_W-1:0] npc_buf_d [BUF_DEPTH];

  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  dec_bundle_t      head_q, head_d;
  logic [NPC_W-1:0] head_npc_q, head_npc_d;

  logic push;
  logic pop;

  lc3_decode_logic u_decode (
    .instr (in_instr),
    .dec   (in_dec)
  );

  assign push = in_valid && in_ready_q && !flush;
  assign pop  = out_valid_q && out_ready && !flush;

  // FIFO bookkeeping; the head registers are loaded from the post-update
  // storage so a push into an emptying FIFO lands on the head directly.
  always_comb begin
    buf_d       = buf_q;
    npc_buf_d   = npc_buf_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    head_d      = head_q;
    head_npc_d  = head_npc_q;

    if (push) begin
      buf_d[wr_ptr_q]     = in_dec;
      npc_buf_d[wr_ptr_q] = in_npc;
      wr_ptr_d            = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end

    if (count_d != '0) begin
      head_d     = buf_d[rd_ptr_d];
      head_npc_d = npc_buf_d[rd_ptr_d];
    end

    out_valid_d = (count_d != '0);
    in_ready_d  = (count_d != CNT_W'(BUF_DEPTH));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < BUF_DEPTH; i++) begin
        buf_q[i]     <= '0;
        npc_buf_q[i] <= '0;
      end
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      head_q      <= '0;
      head_npc_q  <= '0;
    end else begin
      buf_q       <= buf_d;
      npc_buf_q   <= npc_buf_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      head_q      <= head_d;
      head_npc_q  <= head_npc_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign occupancy   = count_q;
  assign IR          = head_q.ir;
  assign npc_out     = head_npc_q;
  assign E_Control   = head_q.e_ctrl;
  assign W_Control   = head_q.w_ctrl;
  assign Mem_Control = head_q.m_ctrl;
  assign illegal_op  = head_q.illegal;

endmodule

// File: tb/tb_lc3_decode_buffered.sv
// Self-checking bench for lc3_decode_buffered: queue-based reference model
// plus directed vectors with literal expectations.
module tb_lc3_decode_buffered;

  localparam int unsigned NPC_W = 16;
  localparam int unsigned DEPTH = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_instr = '0;
  logic [15:0] in_npc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        illegal_op;
  logic [1:0]  occupancy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference decode table indexed by opcode.
  logic [1:0] t_alu [16];
  logic [1:0] t_pc1 [16];
  logic       t_pc2 [16];
  logic       t_imm [16];
  logic [1:0] t_w   [16];
  logic       t_m   [16];
  logic       t_ill [16];

  logic [31:0] mq[$];

  lc3_decode_buffered #(.NPC_W(NPC_W), .BUF_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_npc(in_npc),
    .out_valid(out_valid), .out_ready(out_ready), .IR(IR), .npc_out(npc_out),
    .E_Control(E_Control), .W_Control(W_Control), .Mem_Control(Mem_Control),
    .illegal_op(illegal_op), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic table_row(input int op, input logic [1:0] alu, input logic [1:0] pc1,
                           input logic pc2, input logic imm, input logic [1:0] w,
                           input logic m, input logic ill);
    t_alu[op] = alu; t_pc1[op] = pc1; t_pc2[op] = pc2; t_imm[op] = imm;
    t_w[op] = w; t_m[op] = m; t_ill[op] = ill;
  endtask

  task automatic compare();
    logic [15:0] ins;
    logic [15:0] np;
    int op;
    chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("occupancy", 32'(occupancy), 32'(mq.size()));
    if (mq.size() != 0) begin
      ins = mq[0][31:16];
      np  = mq[0][15:0];
      op  = int'(ins[15:12]);
      chk("IR", 32'(IR), 32'(ins));
      chk("npc_out", 32'(npc_out), 32'(np));
      chk("E_Control", 32'(E_Control),
          32'({t_alu[op], t_pc1[op], t_pc2[op], t_imm[op] & ~ins[5]}));
      chk("W_Control", 32'(W_Control), 32'(t_w[op]));
      chk("Mem_Control", 32'(Mem_Control), 32'(t_m[op]));
      chk("illegal_op", 32'(illegal_op), 32'(t_ill[op]));
    end
  endtask

  task automatic step(input logic v, input logic [15:0] ins, input logic [15:0] np,
                      input logic rdy, input logic fl);
    logic do_push;
    logic do_pop;
    in_valid = v; in_instr = ins; in_npc = np; out_ready = rdy; flush = fl;
    do_push = !reset && !fl && v && (mq.size() < DEPTH);
    do_pop  = !reset && !fl && rdy && (mq.size() != 0);
    @(posedge clock);
    if (reset || fl) mq.delete();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) mq.push_back({ins, np});
    end
    @(negedge clock);
    compare();
  endtask

  initial begin
    logic ill_exp;
`ifdef LC3_DECODE_ILLEGAL_EN
    ill_exp = 1'b1;
`else
    ill_exp = 1'b0;
`endif
    for (int i = 0; i < 16; i++) table_row(i, 2'd0, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, ill_exp);
    table_row(4'b0001, 2'd0, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    table_row(4'b0101, 2'd1, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    table_row(4'b1001, 2'd2, 2'd0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0);
    table_row(4'b0000, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    table_row(4'b1100, 2'd0, 2'd3, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    table_row(4'b0010, 2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b0);
    table_row(4'b0110, 2'd0, 2'd2, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0);
    table_row(4'b1010, 2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 1'b1, 1'b0);
    table_row(4'b1110, 2'd0, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    table_row(4'b0011, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0);
    table_row(4'b0111, 2'd0, 2'd2, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0);
    table_row(4'b1011, 2'd0, 2'd1, 1'b1, 1'b0, 2'd0, 1'b1, 1'b0);

    // Reset state
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_IR", 32'(IR), 32'h0);
    chk("rst_E", 32'(E_Control), 32'h0);
    chk("rst_npc", 32'(npc_out), 32'h0);
    reset = 1'b0;
    step(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);

    // ADD with register operand
    step(1'b1, 16'h1042, 16'h3001, 1'b0, 1'b0);
    chk("add_valid", 32'(out_valid), 32'h1);
    chk("add_E", 32'(E_Control), 32'h01);
    chk("add_W", 32'(W_Control), 32'h0);
    chk("add_M", 32'(Mem_Control), 32'h0);
    chk("add_npc", 32'(npc_out), 32'h3001);

    // Back-to-back stream with out_ready high
    step(1'b1, 16'hA5FF, 16'h3002, 1'b1, 1'b0);
    chk("ldi_E", 32'(E_Control), 32'h06);
    chk("ldi_W", 32'(W_Control), 32'h1);
    chk("ldi_M", 32'(Mem_Control), 32'h1);
    step(1'b1, 16'hE005, 16'h3003, 1'b1, 1'b0);
    chk("lea_E", 32'(E_Control), 32'h06);
    chk("lea_W", 32'(W_Control), 32'h2);
    chk("lea_M", 32'(Mem_Control), 32'h0);
    step(1'b1, 16'h7282, 16'h3004, 1'b1, 1'b0);
    chk("str_E", 32'(E_Control), 32'h08);
    chk("str_W", 32'(W_Control), 32'h0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("drain_valid", 32'(out_valid), 32'h0);

    // Stall with out_ready low: third push must wait for a slot
    step(1'b1, 16'h5020, 16'h4001, 1'b0, 1'b0);
    step(1'b1, 16'h903F, 16'h4002, 1'b0, 1'b0);
    chk("full_in_ready", 32'(in_ready), 32'h0);
    chk("full_occ", 32'(occupancy), 32'h2);
    step(1'b1, 16'h0E07, 16'h4003, 1'b0, 1'b0);
    chk("stall_head", 32'(IR), 32'h5020);
    step(1'b1, 16'h0E07, 16'h4003, 1'b1, 1'b0);
    chk("first_pop_occ", 32'(occupancy), 32'h1);
    step(1'b1, 16'h0E07, 16'h4003, 1'b1, 1'b0);
    chk("third_accepted", 32'(occupancy), 32'h1);
    chk("third_behind", 32'(IR), 32'h0E07);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Simultaneous push and pop at occupancy 1
    step(1'b1, 16'h2405, 16'h5001, 1'b0, 1'b0);
    step(1'b1, 16'h6A81, 16'h5002, 1'b1, 1'b0);
    chk("pp_occ", 32'(occupancy), 32'h1);
    chk("pp_head", 32'(IR), 32'h6A81);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Flush with a full FIFO and an incoming instruction
    step(1'b1, 16'h3605, 16'h6001, 1'b0, 1'b0);
    step(1'b1, 16'hB7FE, 16'h6002, 1'b0, 1'b0);
    step(1'b1, 16'hC1C0, 16'h6003, 1'b1, 1'b1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_occ", 32'(occupancy), 32'h0);
    chk("flush_in_ready", 32'(in_ready), 32'h1);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("flush_stays_empty", 32'(out_valid), 32'h0);

    // Unsupported opcode
    step(1'b1, 16'hF025, 16'h7001, 1'b0, 1'b0);
    chk("ill_flag", 32'(illegal_op), 32'(ill_exp));
    chk("ill_E", 32'(E_Control), 32'h0);
    chk("ill_W", 32'(W_Control), 32'h0);
    chk("ill_M", 32'(Mem_Control), 32'h0);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Every opcode, both operand modes, streaming
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 16'((i % 16) << 12) | 16'((i / 16) << 5) | 16'h0A03,
           16'(16'h8000 + i), 1'b1, 1'b0);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);

    // Reset mid-operation
    step(1'b1, 16'h1234, 16'h9001, 1'b0, 1'b0);
    step(1'b1, 16'h5678, 16'h9002, 1'b0, 1'b0);
    reset = 1'b1;
    step(1'b1, 16'h9ABC, 16'h9003, 1'b1, 1'b0);
    chk("midrst_IR", 32'(IR), 32'h0);
    chk("midrst_npc", 32'(npc_out), 32'h0);
    reset = 1'b0;
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
    chk("midrst_occ", 32'(occupancy), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
